edge_stream_loader: RTL and testbench
=====================================

Name: edge_stream_loader

Overview:
- Upstream feeder for the Dijkstra stage. Accepts a graph header (node count, edge count), then a serial stream of edges, one per valid/ready beat.
- Validates each edge and packs the accepted ones into the flat 3072-bit edge bus with the matching n/e fields.
- Holds the packed graph with out_valid until the downstream stage takes it.
- Removes the need for the testbench or host to drive the full 3084-bit input in a single cycle.

Parameters:
- MAX_EDGES, 256, number of 12-bit entry slots in the packed bus.
- NODE_W, 4, width of node id and node count.
- WEIGHT_W, 4, width of edge weight.
- ECNT_W, 8, width of edge counts.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- cfg_valid  input  1  header present.
- cfg_ready  output  1  high only in IDLE.
- cfg_n  input  4  node count; nodes are numbered 1..cfg_n.
- cfg_e  input  8  number of edge beats to follow.
- in_valid  input  1  edge beat valid.
- in_ready  output  1  high only in LOAD.
- in_parent  input  4  parent node id.
- in_child  input  4  child node id.
- in_weight  input  4  edge weight.
- out_valid  output  1  packed graph available.
- out_ready  input  1  downstream accepts the graph.
- n  output  4  latched cfg_n.
- e  output  8  count of accepted edges.
- data  output  3072  packed entries. Entry k is data[12k+11:12k] = {weight, child, parent}.
- drop_pulse  output  1  one-cycle pulse when an edge beat is rejected.
- drop_cnt  output  8  rejected beats in the current graph; saturates at 255.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - out_valid=0, drop_pulse=0, drop_cnt=0, n=0, e=0, data=0.
  - cfg_ready=1, in_ready=0.
  - Reset mid-LOAD or mid-PRESENT discards the partial or held graph.
- States: IDLE, LOAD, PRESENT.
- IDLE:
  - On cfg_valid&cfg_ready: latch n=cfg_n and rem=cfg_e; clear e, data, drop_cnt.
  - Next state is LOAD if cfg_e!=0, otherwise PRESENT.
  - cfg_valid is ignored in every other state.
- LOAD, per beat (in_valid&in_ready):
  - An edge is valid iff 1<=parent<=n, 1<=child<=n and parent!=child. Weight 0 is legal.
  - Valid edge: written to slot e; e increments. Entries are stored in arrival order and are never reordered.
  - Invalid edge: not stored. drop_pulse=1 on the next cycle; drop_cnt increments, saturating.
  - rem decrements on every accepted beat, valid or not.
  - The beat that brings rem to 0 moves the state to PRESENT.
- LOAD with in_valid=0: no change; the state waits indefinitely.
- PRESENT:
  - out_valid=1; n, e and data are held stable.
  - On out_valid&out_ready: next state IDLE and out_valid=0. data stays at its last value until the next header clears it.
- Latency:
  - Header handshake at cycle T with cfg_e=0: out_valid=1 at T+1.
  - Last edge beat at cycle T: out_valid=1 at T+1, and e already includes that edge.
- Widths and limits:
  - e never exceeds cfg_e, which is at most 255, so slot 255 is always zero.
  - Slots at index e and above are zero.
  - With n=0, every edge is invalid.
- Simultaneous events: out_ready and cfg_valid in the same PRESENT cycle. Only the out handshake happens that cycle; the header can be accepted on the next cycle at the earliest, because cfg_ready rises in IDLE.

Decomposition:
- Shared package graph_pkg:
  - NODE_W, WEIGHT_W, ECNT_W, MAX_EDGES, ENTRY_W=12.
  - Entry field offsets: PARENT_LSB=0, CHILD_LSB=4, WEIGHT_LSB=8.
  - State encoding enum for IDLE/LOAD/PRESENT.
  - The Dijkstra stage uses the same field offsets.
- One sub-module, edge_check: combinational validity check of (parent, child, n) -> ok. Reused later by the Dijkstra adjacency builder.
- The packing register and FSM stay in edge_stream_loader.

Test Plan:
- Header n=3, e=2; edges (1,2,w5) then (2,3,w7), out_ready=1.
  - out_valid rises one cycle after the second beat; n=3, e=2.
  - data[11:0]=12'h521, data[23:12]=12'h732, all other bits 0.
- Header n=4, e=4; edges (1,2,w1), (0,3,w2), (2,2,w3), (4,5,w4).
  - e=1, drop_cnt=3, three drop_pulse pulses, data[11:0]=12'h121, rest 0.
- Header n=5, e=0.
  - out_valid=1 the cycle after the header; e=0, data=0, in_ready never asserted.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid, n, e and data stay stable; cfg_ready=0; cfg_valid pulses are ignored.
- Reset mid-LOAD: drive reset=0 for one clk edge after 3 of 8 beats.
  - Next cycle: IDLE, out_valid=0, data=0, e=0, cfg_ready=1.
  - A new graph then loads correctly.
- Full load: n=15, e=255, random valid edges with in_valid gaps.
  - e=255 and slots 0..254 match the scoreboard in order.
  - Slot 255=0; drop_cnt=0.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared graph constants, entry layout and loader state encoding.
// Entry field offsets are also used by the Dijkstra stage.
package graph_pkg;
  localparam int NODE_W     = 4;
  localparam int WEIGHT_W   = 4;
  localparam int ECNT_W     = 8;
  localparam int MAX_EDGES  = 256;
  localparam int ENTRY_W    = 12;
  localparam int DATA_W     = MAX_EDGES * ENTRY_W;

  localparam int PARENT_LSB = 0;
  localparam int CHILD_LSB  = 4;
  localparam int WEIGHT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t pack_entry(input logic [NODE_W-1:0]   parent,
                                        input logic [NODE_W-1:0]   child,
                                        input logic [WEIGHT_W-1:0] weight);
    entry_t ent;
    ent = '0;
    ent[PARENT_LSB +: NODE_W]   = parent;
    ent[CHILD_LSB +: NODE_W]    = child;
    ent[WEIGHT_LSB +: WEIGHT_W] = weight;
    return ent;
  endfunction
endpackage

// File: rtl/edge_stream_loader_if.sv
// Header, edge-beat and packed-graph handshakes between host and loader.
// master = host/downstream side, slave = edge_stream_loader.
interface edge_stream_loader_if;
  import graph_pkg::*;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [NODE_W-1:0]     cfg_n;
  logic [ECNT_W-1:0]     cfg_e;

  logic                  in_valid;
  logic                  in_ready;
  logic [NODE_W-1:0]     in_parent;
  logic [NODE_W-1:0]     in_child;
  logic [WEIGHT_W-1:0]   in_weight;

  logic                  out_valid;
  logic                  out_ready;
  logic [NODE_W-1:0]     n;
  logic [ECNT_W-1:0]     e;
  logic [DATA_W-1:0]     data;
  logic                  drop_pulse;
  logic [ECNT_W-1:0]     drop_cnt;

  modport master (
    output cfg_valid, cfg_n, cfg_e,
    output in_valid, in_parent, in_child, in_weight,
    output out_ready,
    input  cfg_ready, in_ready, out_valid, n, e, data, drop_pulse, drop_cnt
  );

  modport slave (
    input  cfg_valid, cfg_n, cfg_e,
    input  in_valid, in_parent, in_child, in_weight,
    input  out_ready,
    output cfg_ready, in_ready, out_valid, n, e, data, drop_pulse, drop_cnt
  );
endinterface

// File: rtl/edge_check.sv
// Combinational edge validity: both endpoints in 1..n and no self-loop.
module edge_check
  import graph_pkg::*;
(
  input  logic [NODE_W-1:0] parent,
  input  logic [NODE_W-1:0] child,
  input  logic [NODE_W-1:0] n,
  output logic              ok
);
  assign ok = (parent != '0) && (parent <= n) &&
              (child  != '0) && (child  <= n) &&
              (parent != child);
endmodule

// File: rtl/edge_stream_loader.sv
// Loads a graph header plus serial edge beats, packs valid edges in arrival
// order, and holds the packed graph with out_valid until downstream takes it.
module edge_stream_loader
  import graph_pkg::*;
(
  input logic           clk,
  input logic           reset,
  edge_stream_loader_if.slave bus
);
  state_t                          state, state_nxt;
  logic [NODE_W-1:0]               n_q;
  logic [ECNT_W-1:0]               e_q;
  logic [ECNT_W-1:0]               rem_q;
  logic [ECNT_W-1:0]               drop_cnt_q;
  logic                            drop_pulse_q;
  logic [MAX_EDGES-1:0][ENTRY_W-1:0] slots_q;
  logic                            cfg_fire, in_fire, out_fire, edge_ok;

  edge_check u_edge_check (
    .parent (bus.in_parent),
    .child  (bus.in_child),
    .n      (n_q),
    .ok     (edge_ok)
  );

  assign cfg_fire = bus.cfg_valid && (state == IDLE);
  assign in_fire  = bus.in_valid  && (state == LOAD);
  assign out_fire = bus.out_ready && (state == PRESENT);

  always_comb begin
    state_nxt     = state;
    bus.cfg_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        if (cfg_fire) state_nxt = (bus.cfg_e != '0) ? LOAD : PRESENT;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        if (in_fire && rem_q == ECNT_W'(1)) state_nxt = PRESENT;
      end
      PRESENT: begin
        bus.out_valid = 1'b1;
        if (out_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      n_q          <= '0;
      e_q          <= '0;
      rem_q        <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      slots_q      <= '0;
    end else begin
      state        <= state_nxt;
      drop_pulse_q <= 1'b0;
      if (cfg_fire) begin
        n_q        <= bus.cfg_n;
        rem_q      <= bus.cfg_e;
        e_q        <= '0;
        drop_cnt_q <= '0;
        slots_q    <= '0;
      end
      if (in_fire) begin
        rem_q <= rem_q - ECNT_W'(1);
        if (edge_ok) begin
          // e never exceeds the header count, so slot e is always in range.
          slots_q[e_q] <= pack_entry(bus.in_parent, bus.in_child, bus.in_weight);
          e_q          <= e_q + ECNT_W'(1);
        end else begin
          drop_pulse_q <= 1'b1;
          if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + ECNT_W'(1);
        end
      end
    end
  end

  assign bus.n          = n_q;
  assign bus.e          = e_q;
  assign bus.data       = slots_q;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_edge_stream_loader.sv
// Randomized bench for edge_stream_loader against a queue-based graph model.
module tb_edge_stream_loader;
  import graph_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  edge_stream_loader_if bus ();

  edge_stream_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: header node count, accepted entries in order, drop count.
  int             m_n;
  logic [11:0]    m_q[$];
  int             m_drop;
  int             pulses;
  int             ep[256];
  int             ec[256];
  int             ew[256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_ok(input int p, input int c, input int nn);
    return p >= 1 && p <= nn && c >= 1 && c <= nn && p != c;
  endfunction

  function automatic int slot_errs();
    int bad;
    logic [11:0] exp_v;
    bad = 0;
    for (int k = 0; k < MAX_EDGES; k++) begin
      exp_v = (k < m_q.size()) ? m_q[k] : 12'h000;
      if (bus.data[k*ENTRY_W +: ENTRY_W] !== exp_v) bad++;
    end
    return bad;
  endfunction

  task automatic model_clear();
    m_n = 0;
    m_q.delete();
    m_drop = 0;
    pulses = 0;
  endtask

  task automatic send_header(input int nn, input int ne);
    int w;
    w = 0;
    while (bus.cfg_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("cfg_ready_wait", 32'(bus.cfg_ready), 32'd1);
    bus.cfg_valid = 1'b1;
    bus.cfg_n     = 4'(nn);
    bus.cfg_e     = 8'(ne);
    tick();
    bus.cfg_valid = 1'b0;
    model_clear();
    m_n = nn;
    check("hdr_in_ready", 32'(bus.in_ready), 32'(ne != 0));
    check("hdr_out_valid", 32'(bus.out_valid), 32'(ne == 0));
  endtask

  task automatic send_beats(input int from, input int upto, input int ne, input bit gaps);
    bit ok;
    for (int i = from; i < upto; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          tick();
          check("gap_drop_pulse", 32'(bus.drop_pulse), 32'd0);
          check("gap_out_valid", 32'(bus.out_valid), 32'd0);
        end
      end
      bus.in_valid  = 1'b1;
      bus.in_parent = 4'(ep[i]);
      bus.in_child  = 4'(ec[i]);
      bus.in_weight = 4'(ew[i]);
      tick();
      bus.in_valid = 1'b0;
      ok = model_ok(ep[i], ec[i], m_n);
      if (ok) m_q.push_back({4'(ew[i]), 4'(ec[i]), 4'(ep[i])});
      else    m_drop++;
      check("drop_pulse", 32'(bus.drop_pulse), 32'(!ok));
      pulses += int'(bus.drop_pulse);
      check("beat_out_valid", 32'(bus.out_valid), 32'(i == ne - 1));
    end
  endtask

  task automatic finish_graph(input int hold);
    check("n", 32'(bus.n), 32'(m_n));
    check("e", 32'(bus.e), 32'(m_q.size()));
    check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    check("drop_pulses", 32'(pulses), 32'(m_drop));
    check("slots", 32'(slot_errs()), 32'd0);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      bus.cfg_valid = 1'($urandom_range(0, 1));
      bus.cfg_n     = 4'(m_n + 1);
      bus.cfg_e     = 8'd1;
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_n", 32'(bus.n), 32'(m_n));
      check("bp_e", 32'(bus.e), 32'(m_q.size()));
      check("bp_slots", 32'(slot_errs()), 32'd0);
    end
    // out_ready and cfg_valid together: only the output handshake happens.
    bus.cfg_valid = 1'b1;
    bus.cfg_n     = 4'(m_n + 1);
    bus.cfg_e     = 8'd0;
    bus.out_ready = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("done_out_valid", 32'(bus.out_valid), 32'd0);
    check("done_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("done_n_kept", 32'(bus.n), 32'(m_n));
    check("done_data_kept", 32'(slot_errs()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nn, ne;
    bus.cfg_valid = 1'b0; bus.cfg_n = '0; bus.cfg_e = '0;
    bus.in_valid  = 1'b0; bus.in_parent = '0; bus.in_child = '0; bus.in_weight = '0;
    bus.out_ready = 1'b0;
    model_clear();
    reset = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_n", 32'(bus.n), 32'd0);
    check("rst_e", 32'(bus.e), 32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("rst_drop_pulse", 32'(bus.drop_pulse), 32'd0);
    check("rst_data", 32'(slot_errs()), 32'd0);
    reset = 1'b1;
    tick();

    // Two valid edges.
    ep[0] = 1; ec[0] = 2; ew[0] = 5;
    ep[1] = 2; ec[1] = 3; ew[1] = 7;
    send_header(3, 2);
    send_beats(0, 2, 2, 1'b0);
    check("t1_slot0", 32'(bus.data[11:0]), 32'h521);
    check("t1_slot1", 32'(bus.data[23:12]), 32'h732);
    finish_graph(0);

    // One valid edge, three rejects.
    ep[0] = 1; ec[0] = 2; ew[0] = 1;
    ep[1] = 0; ec[1] = 3; ew[1] = 2;
    ep[2] = 2; ec[2] = 2; ew[2] = 3;
    ep[3] = 4; ec[3] = 5; ew[3] = 4;
    send_header(4, 4);
    send_beats(0, 4, 4, 1'b0);
    check("t2_e", 32'(bus.e), 32'd1);
    check("t2_drop_cnt", 32'(bus.drop_cnt), 32'd3);
    check("t2_slot0", 32'(bus.data[11:0]), 32'h121);
    finish_graph(0);

    // Empty graph under back-pressure.
    send_header(5, 0);
    finish_graph(10);

    // Reset in the middle of a load.
    for (int i = 0; i < 8; i++) begin
      ep[i] = $urandom_range(0, 7); ec[i] = $urandom_range(0, 7); ew[i] = $urandom_range(0, 15);
    end
    send_header(6, 8);
    send_beats(0, 3, 8, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_clear();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_e", 32'(bus.e), 32'd0);
    check("mid_rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("mid_rst_data", 32'(slot_errs()), 32'd0);
    send_header(6, 8);
    send_beats(0, 8, 8, 1'b1);
    finish_graph(3);

    // Random graphs with mixed validity, including n=0.
    for (int g = 0; g < 6; g++) begin
      nn = (g == 0) ? 0 : $urandom_range(1, 15);
      ne = $urandom_range(1, 24);
      for (int i = 0; i < ne; i++) begin
        ep[i] = $urandom_range(0, 15); ec[i] = $urandom_range(0, 15); ew[i] = $urandom_range(0, 15);
      end
      send_header(nn, ne);
      send_beats(0, ne, ne, 1'b1);
      finish_graph($urandom_range(0, 4));
    end

    // Full load: 255 valid edges with input gaps.
    for (int i = 0; i < 255; i++) begin
      ep[i] = $urandom_range(1, 15);
      ec[i] = $urandom_range(1, 14);
      if (ec[i] >= ep[i]) ec[i] = ec[i] + 1;
      ew[i] = $urandom_range(0, 15);
    end
    send_header(15, 255);
    send_beats(0, 255, 255, 1'b1);
    check("full_e", 32'(bus.e), 32'd255);
    check("full_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("full_slot255", 32'(bus.data[DATA_W-1 -: ENTRY_W]), 32'd0);
    finish_graph(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
